// File: rtl/mem_data_buffer.sv
// rtl/mem_data_buffer.sv - load-data FIFO that aligns and extends memory read words at push
module mem_data_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int OFF_W = $clog2(DATA_W / 8),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] memData [DEPTH];
    logic [DEPTH-1:0]  memErr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    logic              push;
    logic              pop;
    logic [1:0]        effSize;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] formatted;
    logic              signBit;
    logic              misaligned;

    assign in_ready  = !reset && !flush && (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Entries are stored already formatted, so the read side is a plain mux.
    assign out_data = out_valid ? memData[rdPtr] : '0;
    assign out_err  = out_valid & memErr[rdPtr];

    always_comb begin
        effSize = in_size;
        if (DATA_W == 32 && in_size == 2'b11) begin
            effSize = 2'b10;
        end
        shifted    = in_data >> {in_offset, 3'b000};
        misaligned = 1'b0;
        mask       = '1;
        signBit    = shifted[DATA_W-1];
        case (effSize)
            2'b00: begin
                mask    = DATA_W'(8'hFF);
                signBit = shifted[7];
            end
            2'b01: begin
                mask       = DATA_W'(16'hFFFF);
                signBit    = shifted[15];
                misaligned = in_offset[0];
            end
            2'b10: begin
                mask       = DATA_W'(32'hFFFF_FFFF);
                signBit    = shifted[31];
                misaligned = (in_offset[1:0] != 2'b00);
            end
            default: begin
                misaligned = (in_offset != '0);
            end
        endcase
        formatted = (shifted & mask) | ((in_signed && signBit) ? ~mask : '0);
        if (misaligned) begin
            formatted = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            memData[wrPtr] <= formatted;
            memErr[wrPtr]  <= misaligned;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule
